// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared types, default sizes and helpers for the adder_seq slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_seq_pkg;

  // Sequencer states: waiting for operands, walking slices, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NSLICE = 4;

  // Slice index width; a single-slice build still needs a 1-bit counter.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_seq_add_slice.sv
// add_slice: one WIDTH-bit adder with carry in and carry out.
// Latency: combinational.
// Backpressure: none.
module add_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] w_full;

  // Add at WIDTH+1 bits so the top bit is the slice carry.
  assign w_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  assign s      = w_full[WIDTH-1:0];
  assign co     = w_full[WIDTH];

endmodule

// File: rtl/adder_seq.sv
// adder_seq: NSLICE*WIDTH-bit add, one WIDTH-bit slice per clock through a single add_slice.
// Latency: out_valid rises NSLICE cycles after the accept edge; initiation interval NSLICE+2.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
// Optional: define ADDER_SEQ_SUB_EN for a 'sub' input that computes a-b (cout=1 means no borrow).
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NSLICE = DEF_NSLICE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSLICE*WIDTH-1:0] a,
  input  logic [NSLICE*WIDTH-1:0] b,
  input  logic                    cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic                    sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NSLICE*WIDTH-1:0] s,
  output logic                    cout,
  output logic                    busy
);

  localparam int TW = NSLICE * WIDTH;
  localparam int IW = idx_width(NSLICE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_a;
  logic [TW-1:0]    r_b;
  logic [TW-1:0]    r_s;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [TW-1:0]    w_b_cap;
  logic             w_c_cap;
  logic [WIDTH-1:0] w_a_slc;
  logic [WIDTH-1:0] w_b_slc;
  logic [WIDTH-1:0] w_sum;
  logic             w_co;

  // Subtraction is a + ~b + 1, so it only changes what gets captured.
`ifdef ADDER_SEQ_SUB_EN
  assign w_b_cap = sub ? ~b : b;
  assign w_c_cap = sub ? 1'b1 : cin;
`else
  assign w_b_cap = b;
  assign w_c_cap = cin;
`endif

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_idx == LAST_IDX);

  // Pick the operand slices addressed by the current index.
  always_comb begin
    w_a_slc = '0;
    w_b_slc = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_slc = r_a[k*WIDTH +: WIDTH];
        w_b_slc = r_b[k*WIDTH +: WIDTH];
      end
    end
  end

  add_slice #(
    .WIDTH (WIDTH)
  ) u_add_slice (
    .a  (w_a_slc),
    .b  (w_b_slc),
    .ci (r_carry),
    .s  (w_sum),
    .co (w_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and state-decoded handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then one slice written per RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_cap;
      r_carry <= w_c_cap;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      for (int k = 0; k < NSLICE; k++) begin
        if (r_idx == IW'(k)) r_s[k*WIDTH +: WIDTH] <= w_sum;
      end
      r_carry <= w_co;
      if (w_last) r_cout <= w_co;
      else        r_idx  <= r_idx + IW'(1);
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq: directed and random checks of adder_seq against a plain-arithmetic model.
// Latency: checks out_valid rises 4 cycles after accept and 6-cycle spacing back-to-back.
// Backpressure: holds out_ready low and checks the result stays frozen.
module tb_adder_seq;

  localparam int W  = 8;
  localparam int NS = 4;
  localparam int TW = W * NS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          cin;
  logic          sub_i;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] s;
  logic          cout;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  longint t_last_acc = -1;

  adder_seq #(.WIDTH(W), .NSLICE(NS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_SEQ_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: wide add of the operands as the spec defines them.
  function automatic logic [TW:0] ref_add(input logic [TW-1:0] ra, input logic [TW-1:0] rb,
                                          input logic rc, input logic rs);
    logic [TW:0] r;
`ifdef ADDER_SEQ_SUB_EN
    if (rs) r = {1'b0, ra} + {1'b0, ~rb} + (TW+1)'(1);
    else    r = {1'b0, ra} + {1'b0, rb} + (TW+1)'(rc);
`else
    r = {1'b0, ra} + {1'b0, rb} + (TW+1)'(rc);
    if (rs) r = r;
`endif
    return r;
  endfunction

  // One operation: accept, check latency/result, optional backpressure hold.
  task automatic do_op(input string tag, input logic [TW-1:0] ta, input logic [TW-1:0] tb_v,
                       input logic tc, input logic ts, input logic [TW-1:0] es,
                       input logic ec, input int hold, input bit chk_ii);
    int cyc;
    logic [TW-1:0] s_hold;
    logic          c_hold;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a         = ta;
    b         = tb_v;
    cin       = tc;
    sub_i     = ts;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    if (chk_ii && t_last_acc >= 0)
      chk({tag, "_ii"}, 64'(($time - t_last_acc) / 10), 64'(NS + 2));
    t_last_acc = $time;
    @(negedge clk);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    // Late operand changes must not reach the result.
    a     = TW'($urandom);
    b     = TW'($urandom);
    cin   = 1'($urandom);
    sub_i = 1'($urandom);
    cyc   = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'(NS));
    chk({tag, "_s"}, 64'(s), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    in_valid = 1'($urandom);
    if (hold > 0) begin
      s_hold = s;
      c_hold = cout;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        a = TW'($urandom);
        b = TW'($urandom);
        chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
        chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
        chk({tag, "_hold_s"}, 64'(s), 64'(s_hold));
        chk({tag, "_hold_cout"}, 64'(cout), 64'(c_hold));
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
      chk({tag, "_idle_vld"}, 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] ra, rb;
    logic          rc, rs;
    logic [TW:0]   r;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub_i     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;

    do_op("carry", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 0, 1'b0);
    do_op("cin", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 0, 1'b0);
    do_op("bp", 32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 32'h00000000, 1'b1, 10, 1'b0);

    // Reset two cycles into RUN discards the operation.
    @(negedge clk);
    a        = 32'h80000000;
    b        = 32'h80000000;
    cin      = 1'b0;
    sub_i    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_s", 64'(s), 64'd0);
    chk("mrst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    do_op("post_rst", 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 0, 1'b0);

`ifdef ADDER_SEQ_SUB_EN
    do_op("sub_neg", 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 0, 1'b0);
    do_op("sub_pos", 32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 0, 1'b0);
`endif

    // Back-to-back random operations at the minimum initiation interval.
    t_last_acc = -1;
    for (int n = 0; n < 512; n++) begin
      ra = TW'($urandom);
      rb = TW'($urandom);
      rc = 1'($urandom);
`ifdef ADDER_SEQ_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      if (n % 64 == 0) ra = '1;
      r = ref_add(ra, rb, rc, rs);
      do_op("rnd", ra, rb, rc, rs, r[TW-1:0], r[TW], 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
